bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the BCD-to-excess-3 stage. Each of its BCD digits feeds that stage's 4-bit BCD input.
- Valid/ready handshake on both sides so it can be placed in a stalling pipeline.

---
 rtl/bcd_pkg.sv | 31 +++
 rtl/bcd_add3_digit.sv | 13 +
 rtl/bin_to_bcd_seq.sv | 125 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, BCD digit geometry and the digit-count helper
// used to reject parameter sets whose result cannot fit in DIGITS digits.
package bcd_pkg;

   localparam int         BCD_DIGIT_W = 4;
   localparam logic [3:0] ADD3_THRESH = 4'd5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Number of decimal digits needed to represent 2^bin_w - 1.
   function automatic int bcd_digits_needed(input int bin_w);
      longint unsigned v_val;
      int              v_n;
      v_val = (64'd1 << bin_w) - 64'd1;
      v_n   = 0;
      for (int i = 0; i < 24; i++) begin
         if (v_val != 64'd0) begin
            v_n   = v_n + 1;
            v_val = v_val / 64'd10;
         end
      end
      if (v_n == 0) v_n = 1;
      return v_n;
   endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit corrector: adds 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_add3_digit
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] i_digit,
   output logic [BCD_DIGIT_W-1:0] o_digit
);

   // Conditional +3 correction
   assign o_digit = (i_digit >= ADD3_THRESH) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; the producer holds valid and data stable until that edge and
// the consumer may hold ready low for as long as it needs.
// Optional leading-zero blanking output digit_en is built when the macro
// BIN_TO_BCD_LZB_EN is defined.
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [BIN_W-1:0]                bin_in,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd_out,
`ifdef BIN_TO_BCD_LZB_EN
   output logic [DIGITS-1:0]               digit_en,
`endif
   output logic                            busy
);

   localparam int BCD_W = BCD_DIGIT_W * DIGITS;
   localparam int SR_W  = BCD_W + BIN_W;
   localparam int CNT_W = $clog2(BIN_W + 1);

   // Reject configurations where the largest input would overflow the digits
   if (DIGITS < bcd_digits_needed(BIN_W)) begin : g_bad_params
      $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
   end

   state_t            r_state;
   state_t            w_next_state;
   logic [SR_W-1:0]   r_sr;
   logic [CNT_W-1:0]  r_cnt;
   logic [BCD_W-1:0]  r_bcd;
   logic [BCD_W-1:0]  w_corr_bcd;
   logic [SR_W-1:0]   w_shifted;
   logic              w_accept;
   logic              w_last;

   // One add-3 corrector per BCD digit of the working register
   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3_digit u_add3 (
         .i_digit (r_sr[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .o_digit (w_corr_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   assign w_shifted = {w_corr_bcd, r_sr[BIN_W-1:0]} << 1;
   assign w_accept  = in_valid && (r_state == IDLE);
   assign w_last    = (r_state == SHIFT) && (r_cnt == CNT_W'(1));

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   // FSM next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_next_state = SHIFT;
         SHIFT:   if (w_last)    w_next_state = DONE;
         DONE:    if (out_ready) w_next_state = IDLE;
         default:                w_next_state = IDLE;
      endcase
   end

   // FSM outputs decoded from the current state
   always_comb begin
      in_ready  = (r_state == IDLE);
      busy      = (r_state == SHIFT);
      out_valid = (r_state == DONE);
   end

   // Working shift register, bit counter and the result register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sr  <= '0;
         r_cnt <= '0;
         r_bcd <= '0;
      end else if (w_accept) begin
         r_sr  <= {{BCD_W{1'b0}}, bin_in};
         r_cnt <= CNT_W'(BIN_W);
      end else if (r_state == SHIFT) begin
         r_sr  <= w_shifted;
         r_cnt <= r_cnt - CNT_W'(1);
         if (w_last) r_bcd <= w_shifted[SR_W-1 -: BCD_W];
      end
   end

   assign bcd_out = r_bcd;

`ifdef BIN_TO_BCD_LZB_EN
   logic [DIGITS-1:0] r_digit_en;
   logic [DIGITS-1:0] w_digit_en;

   // Digit k is shown if it or any more significant digit is non-zero
   always_comb begin
      logic v_any;
      v_any      = 1'b0;
      w_digit_en = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         v_any         = v_any | (w_shifted[BIN_W + k*BCD_DIGIT_W +: BCD_DIGIT_W] != 4'd0);
         w_digit_en[k] = v_any;
      end
      w_digit_en[0] = 1'b1;
   end

   // Enable mask is captured together with the result
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         r_digit_en <= DIGITS'(1);
      else if (w_last) r_digit_en <= w_digit_en;
   end

   assign digit_en = r_digit_en;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed testbench for bin_to_bcd_seq (default parameters, BIN_W=8, DIGITS=3).
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  bin_in;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] bcd_out;
  logic        busy;
`ifdef BIN_TO_BCD_LZB_EN
  logic [2:0]  digit_en;
`endif

  int checks = 0;
  int errors = 0;
  int lat;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_in    (bin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd_out   (bcd_out),
`ifdef BIN_TO_BCD_LZB_EN
    .digit_en  (digit_en),
`endif
    .busy      (busy)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // present one input; returns 1 after the accepting edge (cycle 0)
  task automatic send(input string tag, input logic [7:0] b);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    bin_in   = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // bounded wait for out_valid, reports cycles since the accepting edge
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 30) begin
      tick();
      cycles++;
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic convert(input string tag, input logic [7:0] b, input logic [11:0] exp);
    send(tag, b);
    wait_valid(lat);
    check({tag, "_latency"}, lat, 32'd8);
    check({tag, "_bcd"}, {20'd0, bcd_out}, {20'd0, exp});
    handshake(tag);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bin_in    = 8'd0;
    repeat (3) tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_bcd", {20'd0, bcd_out}, 32'd0);
`ifdef BIN_TO_BCD_LZB_EN
    check("rst_digit_en", {29'd0, digit_en}, 32'd1);
`endif
    rst = 1'b0;
    tick();

    // zero still takes the full eight shifts
    convert("zero", 8'd0, 12'h000);
`ifdef BIN_TO_BCD_LZB_EN
    check("zero_digit_en", {29'd0, digit_en}, 32'b001);
`endif

    // maximum input, with busy/out_valid tracked cycle by cycle
    send("max", 8'd255);
    for (int n = 1; n <= 7; n++) begin
      tick();
      check($sformatf("max_busy_c%0d", n), {31'd0, busy}, 32'd1);
      check($sformatf("max_ov_c%0d", n), {31'd0, out_valid}, 32'd0);
      check($sformatf("max_ir_c%0d", n), {31'd0, in_ready}, 32'd0);
    end
    tick();
    check("max_ov_c8", {31'd0, out_valid}, 32'd1);
    check("max_busy_c8", {31'd0, busy}, 32'd0);
    check("max_bcd", {20'd0, bcd_out}, 32'h255);
    handshake("max");

    // backpressure: result held stable, competing input ignored
    send("bp", 8'd99);
    wait_valid(lat);
    check("bp_latency", lat, 32'd8);
    bin_in   = 8'd17;
    in_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      check($sformatf("bp_ov_%0d", n), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_bcd_%0d", n), {20'd0, bcd_out}, 32'h099);
      check($sformatf("bp_ir_%0d", n), {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    handshake("bp");
    check("bp_hold_idle", {20'd0, bcd_out}, 32'h099);

    // back-to-back with in_valid held high and out_ready tied high
    out_ready = 1'b1;
    bin_in    = 8'd10;
    in_valid  = 1'b1;
    tick();                       // accept 10 (cycle 0)
    bin_in = 8'd200;
    wait_valid(lat);
    check("b2b1_latency", lat, 32'd8);
    check("b2b1_bcd", {20'd0, bcd_out}, 32'h010);
    tick();                       // handshake edge (cycle 9)
    check("b2b_idle_ov", {31'd0, out_valid}, 32'd0);
    check("b2b_idle_ir", {31'd0, in_ready}, 32'd1);
    tick();                       // accept 200 (cycle 10)
    in_valid = 1'b0;
    check("b2b2_busy", {31'd0, busy}, 32'd1);
    repeat (4) tick();
    check("b2b2_hold_prev", {20'd0, bcd_out}, 32'h010);
    wait_valid(lat);
    check("b2b2_latency", lat, 32'd4);
    check("b2b2_bcd", {20'd0, bcd_out}, 32'h200);
    tick();
    check("b2b2_ov_drop", {31'd0, out_valid}, 32'd0);
    repeat (12) tick();
    check("b2b_no_dup", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // asynchronous reset mid-conversion discards the partial result
    send("abort", 8'd173);
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    check("abort_ov", {31'd0, out_valid}, 32'd0);
    check("abort_bcd", {20'd0, bcd_out}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ir", {31'd0, in_ready}, 32'd1);
    tick();
    rst = 1'b0;
    lat = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (out_valid === 1'b1) lat++;
    end
    check("abort_never_valid", lat, 32'd0);
    convert("after_abort", 8'd42, 12'h042);

    // a few more patterns
    convert("one", 8'd1, 12'h001);
    convert("c128", 8'd128, 12'h128);
    convert("c9", 8'd9, 12'h009);
    send("c7", 8'd7);
    wait_valid(lat);
    check("c7_bcd", {20'd0, bcd_out}, 32'h007);
`ifdef BIN_TO_BCD_LZB_EN
    check("c7_digit_en", {29'd0, digit_en}, 32'b001);
`endif
    handshake("c7");
    send("c105", 8'd105);
    wait_valid(lat);
    check("c105_bcd", {20'd0, bcd_out}, 32'h105);
`ifdef BIN_TO_BCD_LZB_EN
    check("c105_digit_en", {29'd0, digit_en}, 32'b111);
`endif
    handshake("c105");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
